tow_referee: RTL and testbench

//  Round sequencer and push arbiter for the tug-of-war game. Runs each round as

---
 rtl/tow_referee_pkg.sv | 23 ++
 rtl/tow_lfsr.sv | 27 ++
 rtl/tow_referee.sv | 129 ++++++++++++
 tb/tb_tow_referee.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tow_referee_pkg.sv
// Shared definitions for the tug-of-war referee: round states and the LFSR
// feedback used to randomise the dark interval.
package tow_referee_pkg;

   typedef enum logic [2:0] {
      ST_DARK,
      ST_LIT,
      ST_WIN_L,
      ST_WIN_R,
      ST_PEN_L,
      ST_PEN_R,
      ST_RELEASE,
      ST_OVER
   } state_t;

   // Feedback taps 16,14,13,11 (bit positions 15,13,12,10).
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] q);
      return {q[14:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/tow_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exposes only the low bits that the
// referee needs to randomise the dark interval.
module tow_lfsr
   import tow_referee_pkg::*;
#(
   parameter logic [15:0] SEED  = 16'hACE1,
   parameter int          OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   output logic [OUT_W-1:0] rnd
);

   logic [15:0] lfsr_reg;

   // A nonzero seed keeps the register out of the all-zero lock-up state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_reg <= SEED;
      end else begin
         lfsr_reg <= lfsr_step(lfsr_reg);
      end
   end

   assign rnd = lfsr_reg[OUT_W-1:0];

endmodule

// File: rtl/tow_referee.sv
// Round sequencer and push arbiter: dark -> lit -> decide, with false-start
// penalties. All outputs are registered decodes of the next state.
module tow_referee
   import tow_referee_pkg::*;
#(
   parameter int          DARK_MIN    = 16,
   parameter int          DARK_RAND_W = 8,
   parameter int          CNT_W       = 17,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic clk,
   input  logic rst,
   input  logic pbl,
   input  logic pbr,
   input  logic game_over,
   output logic blank,
   output logic armed,
   output logic mv_l,
   output logic mv_r,
   output logic foul
);

   localparam logic [CNT_W-1:0] DARK_MIN_C = CNT_W'(DARK_MIN);

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic                   pbl_reg, pbr_reg;
   logic [DARK_RAND_W-1:0] rnd;
   logic [CNT_W-1:0]       cnt_reload;
   logic                   el, er;
   logic                   blank_next, armed_next, mv_l_next, mv_r_next, foul_next;

   tow_lfsr #(
      .SEED  (LFSR_SEED),
      .OUT_W (DARK_RAND_W)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .rnd (rnd)
   );

   assign el         = pbl & ~pbl_reg;
   assign er         = pbr & ~pbr_reg;
   assign cnt_reload = DARK_MIN_C + CNT_W'(rnd);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_DARK: begin
            // A lone edge while dark is a false start, even on the last dark cycle.
            if (el && !er) begin
               state_next = ST_PEN_L;
            end else if (er && !el) begin
               state_next = ST_PEN_R;
            end else if (el && er) begin
               cnt_next = cnt_reload;
            end else if (cnt_reg == '0) begin
               state_next = ST_LIT;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         ST_LIT: begin
            if (el && er) begin
               state_next = ST_RELEASE;
            end else if (el) begin
               state_next = ST_WIN_L;
            end else if (er) begin
               state_next = ST_WIN_R;
            end
         end
         ST_WIN_L, ST_WIN_R, ST_PEN_L, ST_PEN_R: begin
            state_next = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (!pbl && !pbr) begin
               if (game_over) begin
                  state_next = ST_OVER;
               end else begin
                  state_next = ST_DARK;
                  cnt_next   = cnt_reload;
               end
            end
         end
         ST_OVER: begin
            state_next = ST_OVER;
         end
         default: begin
            state_next = ST_DARK;
            cnt_next   = DARK_MIN_C;
         end
      endcase
   end

   // Penalty moves go to the opponent: a left false start steps right.
   always_comb begin
      blank_next = !(state_next == ST_LIT || state_next == ST_OVER);
      armed_next = (state_next == ST_LIT);
      mv_l_next  = (state_next == ST_WIN_L) || (state_next == ST_PEN_R);
      mv_r_next  = (state_next == ST_WIN_R) || (state_next == ST_PEN_L);
      foul_next  = (state_next == ST_PEN_L) || (state_next == ST_PEN_R);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_DARK;
         cnt_reg   <= DARK_MIN_C;
         pbl_reg   <= 1'b0;
         pbr_reg   <= 1'b0;
         blank     <= 1'b1;
         armed     <= 1'b0;
         mv_l      <= 1'b0;
         mv_r      <= 1'b0;
         foul      <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         pbl_reg   <= pbl;
         pbr_reg   <= pbr;
         blank     <= blank_next;
         armed     <= armed_next;
         mv_l      <= mv_l_next;
         mv_r      <= mv_r_next;
         foul      <= foul_next;
      end
   end

endmodule

// File: tb/tb_tow_referee.sv
// Directed bench for tow_referee: a vector table for the opening rounds, then
// hand sequences for tie, held buttons, game over and reset corner cases.
module tb_tow_referee;

   localparam int DARK_MIN = 4;

   // Expected output codes, packed as {blank, armed, mv_l, mv_r, foul}.
   localparam logic [4:0] O_DARK = 5'b10000;
   localparam logic [4:0] O_LIT  = 5'b01000;
   localparam logic [4:0] O_WL   = 5'b10100;
   localparam logic [4:0] O_WR   = 5'b10010;
   localparam logic [4:0] O_PR   = 5'b10101;
   localparam logic [4:0] O_PL   = 5'b10011;
   localparam logic [4:0] O_OVER = 5'b00000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic pbl = 1'b0;
   logic pbr = 1'b0;
   logic game_over = 1'b0;
   logic blank, armed, mv_l, mv_r, foul;

   int n_vec = 0;
   int n_bad = 0;
   logic [15:0] m_lfsr;
   logic [15:0] lfsr_at_drive;

   typedef struct {
      logic       rst;
      logic       pbl;
      logic       pbr;
      logic       go;
      logic [4:0] exp;
   } vec_t;

   vec_t vecs[20];

   tow_referee #(
      .DARK_MIN    (DARK_MIN),
      .DARK_RAND_W (2),
      .CNT_W       (17),
      .LFSR_SEED   (16'hACE1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pbl       (pbl),
      .pbr       (pbr),
      .game_over (game_over),
      .blank     (blank),
      .armed     (armed),
      .mv_l      (mv_l),
      .mv_r      (mv_r),
      .foul      (foul)
   );

   always #5 clk = ~clk;

   // Reference LFSR: x^16 + x^14 + x^13 + x^11, shifting left, seeded 16'hACE1.
   always @(posedge clk or negedge rst) begin
      if (!rst) m_lfsr <= 16'hACE1;
      else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   task automatic chk(input string name, input logic [4:0] exp);
      logic [4:0] got;
      got = {blank, armed, mv_l, mv_r, foul};
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (blank armed mv_l mv_r foul)", name, got, exp);
      end else begin
         $display("ok   %s: %b", name, got);
      end
   endtask

   // Drive inputs on the falling edge, sample outputs just after the rising edge.
   task automatic cyc(input logic a, input logic b, input logic go);
      @(negedge clk);
      pbl = a;
      pbr = b;
      game_over = go;
      lfsr_at_drive = m_lfsr;
      @(posedge clk);
      #1;
   endtask

   // Counts cycles without armed, starting from the current sample.
   task automatic time_dark(input int exp_n, input string name);
      int n;
      n = 0;
      while (!armed && n < 40) begin
         n++;
         cyc(1'b0, 1'b0, 1'b0);
      end
      n_vec++;
      if (!armed || n != exp_n) begin
         n_bad++;
         $display("FAIL %s: dark lasted %0d cycles (armed=%b), expected %0d then armed",
                  name, n, armed, exp_n);
      end else begin
         $display("ok   %s: dark %0d cycles", name, n);
      end
   endtask

   // Release both buttons from RELEASE; dark length follows the LFSR seen at that edge.
   task automatic drop_and_time(input string name);
      int exp_n;
      cyc(1'b0, 1'b0, 1'b0);
      exp_n = DARK_MIN + int'(lfsr_at_drive[1:0]) + 1;
      time_dark(exp_n, name);
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      rst = 1'b0;
      pbl = 1'b0;
      pbr = 1'b0;
      game_over = 1'b0;
      #1;
      chk(name, O_DARK);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, O_DARK};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_DARK};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_DARK};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_DARK};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_DARK};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_LIT};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_LIT};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, O_WL};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, O_DARK};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, O_DARK};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, O_DARK};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, O_PR};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, O_DARK};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, O_DARK};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, O_PL};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, O_DARK};
      vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, O_DARK};
      vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0, O_DARK};
      vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b0, O_DARK};
      vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, O_DARK};

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         rst = vecs[i].rst;
         pbl = vecs[i].pbl;
         pbr = vecs[i].pbr;
         game_over = vecs[i].go;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Finish the dark interval restarted by the simultaneous dark edges.
      for (int k = 0; k < 20 && !armed; k++) cyc(1'b0, 1'b0, 1'b0);
      chk("lit_after_restart", O_LIT);

      // Tie in LIT: no move, then a randomised dark interval.
      cyc(1'b1, 1'b1, 1'b0);
      chk("tie_no_move", O_DARK);
      cyc(1'b1, 1'b1, 1'b0);
      chk("tie_hold", O_DARK);
      drop_and_time("tie_dark_len");

      // Held winner button keeps the referee in RELEASE.
      cyc(1'b1, 1'b0, 1'b0);
      chk("win_l", O_WL);
      for (int k = 0; k < 12; k++) begin
         cyc(1'b1, 1'b0, 1'b0);
         chk($sformatf("hold_rel%0d", k), O_DARK);
      end
      drop_and_time("hold_dark_len");

      // Game over sampled when RELEASE clears; OVER ignores everything.
      cyc(1'b0, 1'b1, 1'b1);
      chk("win_r", O_WR);
      cyc(1'b0, 1'b0, 1'b1);
      chk("release_go", O_DARK);
      cyc(1'b0, 1'b0, 1'b1);
      chk("over", O_OVER);
      cyc(1'b1, 1'b0, 1'b1);
      chk("over_pbl", O_OVER);
      cyc(1'b0, 1'b1, 1'b0);
      chk("over_pbr", O_OVER);
      cyc(1'b1, 1'b1, 1'b0);
      chk("over_both", O_OVER);
      cyc(1'b0, 1'b0, 1'b0);
      chk("over_idle", O_OVER);

      do_reset("rst_in_over");
      time_dark(4, "post_rst_over");

      // Reset in the middle of a dark interval.
      cyc(1'b1, 1'b0, 1'b0);
      chk("win_l2", O_WL);
      cyc(1'b0, 1'b0, 1'b0);
      chk("release2", O_DARK);
      cyc(1'b0, 1'b0, 1'b0);
      chk("dark2", O_DARK);
      do_reset("rst_in_dark");

      // Push on the cnt==0 dark cycle is still a false start.
      cyc(1'b0, 1'b0, 1'b0);
      chk("cnt2", O_DARK);
      cyc(1'b0, 1'b0, 1'b0);
      chk("cnt1", O_DARK);
      cyc(1'b0, 1'b0, 1'b0);
      chk("cnt0", O_DARK);
      cyc(1'b1, 1'b0, 1'b0);
      chk("foul_at_cnt0", O_PL);
      cyc(1'b1, 1'b0, 1'b0);
      chk("foul_pulse_end", O_DARK);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
